// File: rtl/ula_seq.sv
// Registered MIC-1 ULA with valid/ready handshake and an iterative
// shift-add multiplier mapped onto the otherwise unused shifter code 2'b11.
module ula_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [7:0]       select,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             n_q, n_d, z_q, z_d, c_q, c_d;
  logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] a_op, b_op, alu_res, shift_res, acc_step;
  logic [WIDTH:0]   sum;
  logic             alu_c;
  logic             accept;
  logic             is_mul;

  // Combinational MIC-1 ALU followed by the shifter.
  // NOTE: every signal assigned in an always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    a_op = select[3] ? A : '0;
    if (select[1]) a_op = ~a_op;
    b_op  = select[2] ? B : '0;
    sum   = {1'b0, a_op} + {1'b0, b_op} + {{WIDTH{1'b0}}, select[0]};
    alu_c = 1'b0;
    case (select[5:4])
      2'b00:   alu_res = a_op & b_op;
      2'b01:   alu_res = a_op | b_op;
      2'b10:   alu_res = ~b_op;
      default: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
      end
    endcase
    case (select[7:6])
      2'b10:   shift_res = alu_res << 8;
      2'b01:   shift_res = {alu_res[WIDTH-1], alu_res[WIDTH-1:1]};
      default: shift_res = alu_res;
    endcase
  end

  assign is_mul   = (select[7:6] == 2'b11);
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign in_ready = (state_q == IDLE) || (state_q == HOLD && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    n_d      = n_q;
    z_d      = z_q;
    c_d      = c_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;

    case (state_q)
      MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          out_d   = acc_step;
          n_d     = acc_step[WIDTH-1];
          z_d     = (acc_step == '0);
          c_d     = 1'b0;
          state_d = HOLD;
        end
      end
      HOLD:    if (out_ready) state_d = IDLE;
      default: ;
    endcase

    // A new operation loads identically from IDLE and from a draining HOLD.
    if (accept) begin
      if (is_mul) begin
        acc_d    = '0;
        mcand_d  = A;
        mplier_d = B;
        cnt_d    = '0;
        state_d  = MUL;
      end else begin
        out_d   = shift_res;
        n_d     = alu_res[WIDTH-1];
        z_d     = (alu_res == '0);
        c_d     = alu_c;
        state_d = HOLD;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      out_q    <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      n_q      <= n_d;
      z_q      <= z_d;
      c_q      <= c_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out       = out_q;
  assign N         = n_q;
  assign Z         = z_q;
  assign C         = c_q;
  assign out_valid = (state_q == HOLD);

endmodule

// File: tb/tb_ula_seq.sv
// Self-checking bench for ula_seq: table-driven ALU/MUL vectors feeding a
// scoreboard queue, plus hand sequences for backpressure and resets.
module tb_ula_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] A, B;
  logic [7:0]   select;
  logic         in_valid, in_ready;
  logic [W-1:0] out;
  logic         N, Z, C, out_valid, out_ready;

  ula_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .select(select),
    .in_valid(in_valid), .in_ready(in_ready), .out(out),
    .N(N), .Z(Z), .C(C), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [7:0]   sel;
    logic [W-1:0] res;
    logic         n;
    logic         z;
    logic         c;
  } vec_t;

  typedef struct {
    vec_t v;
    int   due;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Drives one op at a negedge, waits (bounded) for in_ready, records the
  // expected result and its due sample cycle, returns just after the accept edge.
  task automatic send(input vec_t v, input logic ordy);
    int waitc = 0;
    @(negedge clk);
    A = v.a; B = v.b; select = v.sel; in_valid = 1'b1; out_ready = ordy;
    #1;
    while (!in_ready && waitc < 100) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    if (!in_ready) begin
      check("send_timeout", 64'(in_ready), 64'd1);
    end else begin
      sb.push_back('{v, cyc + 1 + ((v.sel[7:6] == 2'b11) ? W : 0)});
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  // Output monitor: compares every valid cycle against the queue head and
  // checks latency on the first cycle each result appears.
  logic fresh = 1'b1;
  always @(negedge clk) begin
    #2;
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", 64'(out_valid), 64'd0);
      end else begin
        if (fresh) check("latency", 64'(cyc), 64'(sb[0].due));
        check("out", 64'(out), 64'(sb[0].v.res));
        check("flags_nzc", 64'({N, Z, C}), 64'({sb[0].v.n, sb[0].v.z, sb[0].v.c}));
        if (out_ready) begin
          void'(sb.pop_front());
          fresh = 1'b1;
        end else begin
          fresh = 1'b0;
        end
      end
    end else begin
      fresh = 1'b1;
    end
  end

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  vec_t tbl[15];
  vec_t v;
  logic [W-1:0] held;
  int   busy;
  logic seen_valid;

  initial begin
    tbl[0]  = '{32'd1, 32'd2, 8'h18, 32'd1,        1'b0, 1'b0, 1'b0};
    tbl[1]  = '{32'd1, 32'd2, 8'h14, 32'd2,        1'b0, 1'b0, 1'b0};
    tbl[2]  = '{32'd1, 32'd2, 8'h1A, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{32'd1, 32'd2, 8'h3C, 32'd3,        1'b0, 1'b0, 1'b0};
    tbl[4]  = '{32'd1, 32'd2, 8'h3D, 32'd4,        1'b0, 1'b0, 1'b0};
    tbl[5]  = '{32'd1, 32'd2, 8'h3F, 32'd1,        1'b0, 1'b0, 1'b1};
    tbl[6]  = '{32'd1, 32'd2, 8'h3B, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{32'd1, 32'd2, 8'h0C, 32'd0,        1'b0, 1'b1, 1'b0};
    tbl[8]  = '{32'd1, 32'd2, 8'h32, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{32'h80000000, 32'h80000000, 8'h7C, 32'd0, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{32'h000000FF, 32'd0, 8'h98, 32'h0000FF00, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{32'h80000000, 32'd0, 8'h58, 32'hC0000000, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{32'd0, 32'd2, 8'h24, 32'hFFFFFFFD, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{32'hFFFFFFFF, 32'd2, 8'hC0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{32'd0, 32'd7, 8'hFF, 32'd0, 1'b0, 1'b1, 1'b0};

    reset = 1'b1; A = '0; B = '0; select = '0; in_valid = 1'b0; out_ready = 1'b1;
    #3;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out", 64'(out), 64'd0);
    repeat (2) @(posedge clk);
    #4 reset = 1'b0;

    // ALU sweep and shifter/carry vectors, one per cycle.
    for (int i = 0; i < 13; i++) send(tbl[i], 1'b1);

    // Multiply: in_ready low for exactly WIDTH cycles.
    v = '{32'd1234, 32'd5678, 8'hC0, 32'd7006652, 1'b0, 1'b0, 1'b0};
    send(v, 1'b1);
    busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (in_ready) break;
      busy++;
    end
    check("mul_busy_cycles", 64'(busy), 64'(W));
    send(tbl[13], 1'b1);
    send(tbl[14], 1'b1);
    drain();

    // Backpressure: result held 5 cycles, competing request ignored.
    v = '{32'd9, 32'd6, 8'h3C, 32'd15, 1'b0, 1'b0, 1'b0};
    send(v, 1'b0);
    held = 32'd15;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      A = 32'd100; B = 32'd100; select = 8'h3C; in_valid = 1'b1;
      #1;
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_stable", 64'(out), 64'(held));
    end
    @(negedge clk);
    A = 32'd1; B = 32'd2; select = 8'h14; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    sb.push_back('{'{32'd1, 32'd2, 8'h14, 32'd2, 1'b0, 1'b0, 1'b0}, cyc + 1});
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain();

    // Asynchronous reset while a result is held.
    v = '{32'd5, 32'd7, 8'h3C, 32'd12, 1'b0, 1'b0, 1'b0};
    send(v, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    sb.delete();
    #1;
    check("mid_rst_out", 64'(out), 64'd0);
    check("mid_rst_nzc", 64'({N, Z, C}), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    #1 reset = 1'b0;
    out_ready = 1'b1;

    // Reset at MUL cycle 10 discards the multiply.
    v = '{32'd1234, 32'd5678, 8'hC0, 32'd7006652, 1'b0, 1'b0, 1'b0};
    send(v, 1'b1);
    repeat (9) @(posedge clk);
    #2 reset = 1'b1;
    sb.delete();
    #1;
    check("mulrst_in_ready", 64'(in_ready), 64'd1);
    #1 reset = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) seen_valid = 1'b1;
    end
    check("mulrst_no_pulse", 64'(seen_valid), 64'd0);
    v = '{32'd5, 32'd7, 8'h3C, 32'd12, 1'b0, 1'b0, 1'b0};
    send(v, 1'b1);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ula_seq.md
# ula_seq

Parametrised, registered successor to the combinational MIC-1 ULA. It keeps the MIC-1 8-bit `select` encoding for ALU function and shifter, and registers the result and the N/Z/C flags behind a valid/ready handshake. It adds an iterative shift-add multiply mode on the shifter code that MIC-1 leaves illegal. It sits between the B-bus/H register and the C-bus in the datapath; the control store waits on `out_valid` instead of assuming a zero-delay ALU.

## Interface
- `WIDTH`, default 32: datapath width; legal range is ≥16, because SLL8 must be meaningful.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `A`  in  WIDTH  operand A (H register).
- `B`  in  WIDTH  operand B (B bus).
- `select`  in  8  {SLL8, SRA1, F0, F1, ENA, ENB, INVA, INC}, bit 7 down to bit 0.
- `in_valid`  in  1  operands and select are valid this cycle.
- `in_ready`  out  1  block accepts an operation this cycle.
- `out`  out  WIDTH  registered result.
- `N`  out  1  registered negative flag.
- `Z`  out  1  registered zero flag.
- `C`  out  1  registered adder carry-out.
- `out_valid`  out  1  `out`/`N`/`Z`/`C` hold a result not yet consumed.
- `out_ready`  in  1  consumer takes the result this cycle.

## Operation
- Accept occurs when `in_valid && in_ready` at a rising edge.
- ALU path, taken when `select[7:6] != 2'b11`:
  - Masked operands: `a = ENA ? A : 0`, then inverted if INVA; `b = ENB ? B : 0`.
  - {F0,F1} = 00: `a & b`. 01: `a | b`. 10: `~b`. 11: `a + b + INC`.
  - Arithmetic is modulo 2^WIDTH.
  - `C` is the carry out of bit WIDTH-1 for F=11; otherwise 0.
  - `N` is bit WIDTH-1 of the pre-shift ALU result; `Z` is (pre-shift ALU result == 0).
  - Shifter: SLL8 gives `res << 8` (zero fill). SRA1 gives arithmetic right shift by 1 (sign fill). 00 gives no shift.
- MUL path, taken when `select[7:6] == 2'b11`; `select[5:0]` is ignored:
  - Computes the unsigned product `A * B`; only the low WIDTH bits are kept.
  - On accept: `acc=0`, `mcand=A`, `mplier=B`, `cnt=0`.
  - Each MUL cycle: `acc += mplier[0] ? mcand : 0`, then `mcand <<= 1`, `mplier >>= 1`, `cnt++`.
  - Runs exactly WIDTH cycles; there is no early termination.
  - Final flags: `N` = product bit WIDTH-1, `Z` = (product == 0), `C` = 0.
- State machine: IDLE, MUL, HOLD.
  - IDLE: accept ALU op → HOLD, with out/flags registered at the same edge. Accept MUL → MUL.
  - MUL: at the edge where `cnt == WIDTH-1`, write `acc_next` to `out`, write the flags, go to HOLD. `in_ready = 0` throughout.
  - HOLD: `out_valid = 1`. If `out_ready` and there is no accept → IDLE. If `out_ready` and an accept occurs, load the new op exactly as IDLE would (back-to-back).
  - HOLD with `out_ready = 0`: hold everything stable, `in_ready = 0`.
- `in_ready = (state == IDLE) || (state == HOLD && out_ready)`.
- In IDLE, `out`/`N`/`Z`/`C` keep their last values; `out_valid = 0`.

## Timing
- Reset values: state = IDLE, `out = 0`, `N = 0`, `Z = 0`, `C = 0`, `out_valid = 0`, MUL registers cleared.
  - `in_ready = 1` during and after reset.
- Reset asserted mid-MUL or in HOLD discards the operation immediately, with no output pulse.
- ALU latency: accept at edge k → `out_valid` high after edge k; result visible in cycle k+1.
- MUL latency: accept at edge k → `out_valid` after edge k+WIDTH.
- Throughput: one ALU op per cycle while `out_ready` stays high.
- `out`/flags never change while `out_valid && !out_ready`.
- `in_valid` while `in_ready = 0` is ignored; the producer must hold its request.

## Test plan
All scenarios use WIDTH = 32.
- Reset: assert `reset` asynchronously mid-cycle → `out = 0`, `N = Z = C = 0`, `out_valid = 0`, `in_ready = 1` before the next edge.
- ALU sweep: `A = 1`, `B = 2`, `out_ready = 1`, one op per cycle. Each result must appear one cycle after its accept:
  - 0x18 → 1.
  - 0x14 → 2.
  - 0x1A → 0xFFFFFFFE, N = 1.
  - 0x3C → 3.
  - 0x3D → 4.
  - 0x3F → 1.
  - 0x3B → 0xFFFFFFFF, N = 1.
  - 0x0C → 0, Z = 1.
  - 0x32 → 0xFFFFFFFF.
- Shifter/carry: `A = 0x80000000`, `B = 0x80000000`, select 0x7C (SRA1 + add) → `out = 0`, `C = 1`, `Z = 1`.
  - `A = 0x000000FF`, select 0x98 (SLL8 + A) → `out = 0x0000FF00`, N = 0.
- Multiply: `A = 1234`, `B = 5678`, select 0xC0 → `in_ready = 0` for 32 cycles, then `out = 7006652`, `out_valid = 1`.
  - `A = 0xFFFFFFFF`, `B = 2` → `out = 0xFFFFFFFE`, N = 1, C = 0.
- Backpressure: ALU result held with `out_ready = 0` for 5 cycles → `out` stable, `in_ready = 0`, new `in_valid` ignored.
  - Then raise `out_ready` together with `in_valid` → both transfers occur at the same edge, and the next result is valid one cycle later.
- Reset mid-MUL: assert `reset` at MUL cycle 10 → `out_valid` never rises, state is IDLE, next ALU op 0x3C with `A = 5`, `B = 7` → 12.
